// File: rtl/spi_pkg.sv
// Shared SPI master definitions: command encodings, frame widths and FSM state type.
package spi_pkg;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   localparam int unsigned FRAME_W = 10;
   localparam int unsigned DATA_W  = 8;

   typedef enum logic [2:0] {
      StIdle,
      StSelect,
      StShift,
      StTurn,
      StRecv,
      StGap
   } spi_state_e;

endpackage

// File: rtl/spi_master_shifter.sv
// TX (10-bit, MSB first) and RX (8-bit, MSB first) shift registers for the SPI master.
module spi_master_shifter
   import spi_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               tx_load_i,
   input  logic [FRAME_W-1:0] tx_data_i,
   input  logic               tx_shift_i,
   input  logic               rx_shift_i,
   input  logic               rx_bit_i,
   output logic               tx_bit_o,
   output logic [DATA_W-1:0]  rx_data_o
);

   logic [FRAME_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0]  rx_q, rx_d;

   always_comb begin
      tx_d = tx_q;
      rx_d = rx_q;
      if (tx_load_i) begin
         tx_d = tx_data_i;
      end else if (tx_shift_i) begin
         tx_d = {tx_q[FRAME_W-2:0], 1'b0};
      end
      if (rx_shift_i) begin
         rx_d = {rx_q[DATA_W-2:0], rx_bit_i};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tx_q <= '0;
         rx_q <= '0;
      end else begin
         tx_q <= tx_d;
         rx_q <= rx_d;
      end
   end

   assign tx_bit_o  = tx_q[FRAME_W-1];
   assign rx_data_o = rx_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master command controller: select bit, 10-bit frame, optional turnaround and 8-bit read.
// Optional read-sequence checker enabled by defining SPI_MASTER_SEQ_CHECK_EN.
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int unsigned BIT_CYCLES  = 1,
   parameter int unsigned TURN_CYCLES = 1,
   parameter int unsigned GAP_CYCLES  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       busy,
   output logic       ss_n,
   output logic       mosi,
   input  logic       miso
`ifdef SPI_MASTER_SEQ_CHECK_EN
   ,
   output logic       rd_seq_err
`endif
);

   localparam int unsigned CNT_W = 8;
   localparam logic [3:0]       BIT_LAST   = 4'(BIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(DATA_W - 1);

   spi_state_e        state_q, state_d;
   logic [3:0]        cyc_q, cyc_d;
   logic [CNT_W-1:0]  bit_q, bit_d;
   logic [1:0]        cmd_q, cmd_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

   logic              tx_load, tx_shift, rx_shift, tx_bit, bit_end;
   logic [DATA_W-1:0] rx_data;
   logic              unused_rx_msb;

   assign bit_end       = (cyc_q == BIT_LAST);
   assign unused_rx_msb = rx_data[DATA_W-1];

   always_comb begin
      state_d     = state_q;
      cyc_d       = bit_end ? 4'd0 : cyc_q + 4'd1;
      bit_d       = bit_q;
      cmd_d       = cmd_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      tx_load     = 1'b0;
      tx_shift    = 1'b0;
      rx_shift    = 1'b0;
      cmd_ready   = 1'b0;
      busy        = 1'b1;
      ss_n        = 1'b0;
      mosi        = 1'b0;
      unique case (state_q)
         StIdle: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            ss_n      = 1'b1;
            cyc_d     = 4'd0;
            bit_d     = '0;
            if (cmd_valid) begin
               cmd_d   = cmd;
               tx_load = 1'b1;
               state_d = StSelect;
            end
         end
         StSelect: begin
            mosi = cmd_q[1];
            if (bit_end) begin
               state_d = StShift;
               bit_d   = SHIFT_LAST;
            end
         end
         StShift: begin
            mosi     = tx_bit;
            tx_shift = bit_end;
            if (bit_end) begin
               if (bit_q != '0) begin
                  bit_d = bit_q - CNT_W'(1);
               end else if (cmd_q != CMD_RD_DATA) begin
                  state_d = StGap;
                  bit_d   = GAP_LAST;
               end else if (TURN_CYCLES != 0) begin
                  state_d = StTurn;
                  bit_d   = TURN_LAST;
               end else begin
                  state_d = StRecv;
                  bit_d   = RECV_LAST;
               end
            end
         end
         StTurn: begin
            if (bit_end) begin
               if (bit_q != '0) begin
                  bit_d = bit_q - CNT_W'(1);
               end else begin
                  state_d = StRecv;
                  bit_d   = RECV_LAST;
               end
            end
         end
         StRecv: begin
            rx_shift = bit_end;
            if (bit_end) begin
               if (bit_q != '0) begin
                  bit_d = bit_q - CNT_W'(1);
               end else begin
                  // Capture includes the bit being sampled on this same edge.
                  state_d     = StGap;
                  bit_d       = GAP_LAST;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = {rx_data[DATA_W-2:0], miso};
               end
            end
         end
         StGap: begin
            ss_n  = 1'b1;
            cyc_d = 4'd0;
            if (bit_q != '0) begin
               bit_d = bit_q - CNT_W'(1);
            end else begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cyc_q       <= 4'd0;
         bit_q       <= '0;
         cmd_q       <= 2'b00;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         bit_q       <= bit_d;
         cmd_q       <= cmd_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;

   spi_master_shifter u_shifter (
      .clk_i      (clk),
      .rst_i      (rst),
      .tx_load_i  (tx_load),
      .tx_data_i  ({cmd, cmd_data}),
      .tx_shift_i (tx_shift),
      .rx_shift_i (rx_shift),
      .rx_bit_i   (miso),
      .tx_bit_o   (tx_bit),
      .rx_data_o  (rx_data)
   );

`ifdef SPI_MASTER_SEQ_CHECK_EN
   logic rd_addr_seen_q, rd_addr_seen_d;
   logic rd_seq_err_q, rd_seq_err_d;

   always_comb begin
      rd_addr_seen_d = rd_addr_seen_q;
      rd_seq_err_d   = rd_seq_err_q;
      if (cmd_valid && cmd_ready) begin
         if (cmd == CMD_RD_ADDR) begin
            rd_addr_seen_d = 1'b1;
         end else if (cmd == CMD_RD_DATA) begin
            rd_addr_seen_d = 1'b0;
            if (!rd_addr_seen_q) begin
               rd_seq_err_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_addr_seen_q <= 1'b0;
         rd_seq_err_q   <= 1'b0;
      end else begin
         rd_addr_seen_q <= rd_addr_seen_d;
         rd_seq_err_q   <= rd_seq_err_d;
      end
   end

   assign rd_seq_err = rd_seq_err_q;
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: vector table, read-data scoreboard, corner sequences.
module tb_spi_master_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid, cmd_ready, rsp_valid, busy, ss_n, mosi, miso;
   logic [1:0] cmd;
   logic [7:0] cmd_data, rsp_data;

   logic       cmd_valid4, cmd_ready4, rsp_valid4, busy4, ss_n4, mosi4, miso4;
   logic [1:0] cmd4;
   logic [7:0] cmd_data4, rsp_data4;
`ifdef SPI_MASTER_SEQ_CHECK_EN
   logic       rd_seq_err, rd_seq_err4;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   logic [7:0] held_rsp;

   typedef struct {
      logic [1:0]  cmd;
      logic [7:0]  data;
      logic [7:0]  slave;
      logic [10:0] mosi;
      logic [7:0]  rsp;
   } vec_t;

   vec_t vecs[6];

   always #5 clk = ~clk;

   spi_master_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd       (cmd),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .busy      (busy),
      .ss_n      (ss_n),
      .mosi      (mosi),
      .miso      (miso)
`ifdef SPI_MASTER_SEQ_CHECK_EN
      ,
      .rd_seq_err(rd_seq_err)
`endif
   );

   spi_master_ctrl #(.BIT_CYCLES(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid4),
      .cmd_ready (cmd_ready4),
      .cmd       (cmd4),
      .cmd_data  (cmd_data4),
      .rsp_valid (rsp_valid4),
      .rsp_data  (rsp_data4),
      .busy      (busy4),
      .ss_n      (ss_n4),
      .mosi      (mosi4),
      .miso      (miso4)
`ifdef SPI_MASTER_SEQ_CHECK_EN
      ,
      .rd_seq_err(rd_seq_err4)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every rsp_valid pulse must match the oldest pending read-data expectation.
   always @(negedge clk) begin
      if (rst === 1'b0 && rsp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            chk("rsp_data_sb", 32'(rsp_data), 32'(e));
         end
      end
   end

   task automatic check_frame_bits(input logic [10:0] exp_bits);
      for (int k = 0; k < 11; k++) begin
         chk("ss_n_frame", 32'(ss_n), 32'd0);
         chk("mosi_bit", 32'(mosi), 32'(exp_bits[10-k]));
         chk("busy_frame", 32'(busy), 32'd1);
         step();
      end
   endtask

   task automatic check_gap(input bit rd);
      for (int g = 0; g < 3; g++) begin
         chk("ss_n_gap", 32'(ss_n), 32'd1);
         chk("mosi_gap", 32'(mosi), 32'd0);
         chk("cmd_ready_gap", 32'(cmd_ready), 32'd0);
         chk("rsp_valid_gap", 32'(rsp_valid), 32'(rd && g == 0));
         step();
      end
      chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      chk("busy_idle", 32'(busy), 32'd0);
   endtask

   task automatic do_frame(input vec_t v);
      bit rd;
      rd        = (v.cmd == 2'b11);
      cmd_valid = 1'b1;
      cmd       = v.cmd;
      cmd_data  = v.data;
      chk("cmd_ready_T", 32'(cmd_ready), 32'd1);
      if (rd) exp_q.push_back(v.rsp);
      step();
      cmd_valid = 1'b0;
      check_frame_bits(v.mosi);
      if (rd) begin
         chk("ss_n_turn", 32'(ss_n), 32'd0);
         chk("mosi_turn", 32'(mosi), 32'd0);
         step();
         for (int j = 0; j < 8; j++) begin
            miso = v.slave[7-j];
            chk("ss_n_recv", 32'(ss_n), 32'd0);
            chk("rsp_valid_recv", 32'(rsp_valid), 32'd0);
            step();
         end
         miso     = 1'b0;
         held_rsp = v.rsp;
      end
      check_gap(rd);
      chk("rsp_data_hold", 32'(rsp_data), 32'(held_rsp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   initial begin
      int rv_cnt;
      int low_cnt;
      logic [10:0] ff_bits;

      vecs[0] = '{cmd: 2'b00, data: 8'h05, slave: 8'h00, mosi: 11'b0_00_0000_0101, rsp: 8'h00};
      vecs[1] = '{cmd: 2'b01, data: 8'hA3, slave: 8'h00, mosi: 11'b0_01_1010_0011, rsp: 8'h00};
      vecs[2] = '{cmd: 2'b10, data: 8'h05, slave: 8'h00, mosi: 11'b1_10_0000_0101, rsp: 8'h00};
      vecs[3] = '{cmd: 2'b11, data: 8'h00, slave: 8'h3C, mosi: 11'b1_11_0000_0000, rsp: 8'h3C};
      vecs[4] = '{cmd: 2'b10, data: 8'h7E, slave: 8'h00, mosi: 11'b1_10_0111_1110, rsp: 8'h00};
      vecs[5] = '{cmd: 2'b11, data: 8'h00, slave: 8'hA5, mosi: 11'b1_11_0000_0000, rsp: 8'hA5};

      rst = 1'b1;
      cmd_valid = 1'b0; cmd = 2'b00; cmd_data = 8'h00; miso = 1'b0;
      cmd_valid4 = 1'b0; cmd4 = 2'b00; cmd_data4 = 8'h00; miso4 = 1'b0;
      held_rsp = 8'h00;
      repeat (3) step();
      chk("rst_ss_n", 32'(ss_n), 32'd1);
      chk("rst_mosi", 32'(mosi), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'h00);
`ifdef SPI_MASTER_SEQ_CHECK_EN
      chk("rst_rd_seq_err", 32'(rd_seq_err), 32'd0);
`endif
      rst = 1'b0;
      step();

      foreach (vecs[i]) do_frame(vecs[i]);
      repeat (4) step();
      chk("rsp_data_held_late", 32'(rsp_data), 32'hA5);

      // Valid held through a whole frame: ignored while busy, accepted once back in idle.
      cmd_valid = 1'b1; cmd = 2'b01; cmd_data = 8'h11;
      step();
      cmd_data = 8'h22;
      check_frame_bits(11'b0_01_0001_0001);
      check_gap(1'b0);
      step();
      cmd_valid = 1'b0;
      check_frame_bits(11'b0_01_0010_0010);
      check_gap(1'b0);

      // Reset in the middle of a read-data frame.
      cmd_valid = 1'b1; cmd = 2'b11; cmd_data = 8'h00;
      step();
      cmd_valid = 1'b0;
      miso = 1'b1;
      repeat (5) step();
      chk("mid_ss_n_before_rst", 32'(ss_n), 32'd0);
      rst = 1'b1;
      step();
      chk("mid_rst_ss_n", 32'(ss_n), 32'd1);
      chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_mosi", 32'(mosi), 32'd0);
      chk("mid_rst_rsp_data", 32'(rsp_data), 32'h00);
`ifdef SPI_MASTER_SEQ_CHECK_EN
      chk("mid_rst_rd_seq_err", 32'(rd_seq_err), 32'd0);
`endif
      rst = 1'b0;
      miso = 1'b0;
      held_rsp = 8'h00;
      rv_cnt = 0; low_cnt = 0;
      for (int c = 0; c < 30; c++) begin
         if (rsp_valid === 1'b1) rv_cnt++;
         if (ss_n !== 1'b1) low_cnt++;
         step();
      end
      chk("mid_rst_no_rsp", 32'(rv_cnt), 32'd0);
      chk("mid_rst_no_resume", 32'(low_cnt), 32'd0);

      // Read-data straight after reset, with no preceding read-address.
      do_frame('{cmd: 2'b11, data: 8'h00, slave: 8'h5A, mosi: 11'b1_11_0000_0000, rsp: 8'h5A});
`ifdef SPI_MASTER_SEQ_CHECK_EN
      chk("seq_err_set", 32'(rd_seq_err), 32'd1);
      do_frame(vecs[2]);
      repeat (5) step();
      chk("seq_err_sticky", 32'(rd_seq_err), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("seq_err_cleared", 32'(rd_seq_err), 32'd0);
      held_rsp = 8'h00;
      step();
`endif

      // Slow instance: each bit held for four clocks.
      ff_bits = 11'b0_00_1111_1111;
      cmd_valid4 = 1'b1; cmd4 = 2'b00; cmd_data4 = 8'hFF;
      chk("bc4_cmd_ready_T", 32'(cmd_ready4), 32'd1);
      step();
      cmd_valid4 = 1'b0;
      for (int k = 0; k < 44; k++) begin
         chk("bc4_ss_n", 32'(ss_n4), 32'd0);
         chk("bc4_mosi", 32'(mosi4), 32'(ff_bits[10 - k/4]));
         step();
      end
      chk("bc4_ss_n_end", 32'(ss_n4), 32'd1);
      chk("bc4_busy_gap", 32'(busy4), 32'd1);
      repeat (3) step();
      chk("bc4_cmd_ready_idle", 32'(cmd_ready4), 32'd1);
      chk("bc4_no_rsp", 32'(rsp_valid4), 32'd0);
      chk("bc4_rsp_data", 32'(rsp_data4), 32'h00);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
